// File: rtl/mb_alu_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer.
//   op_mne      : ALU operation mnemonics (4-bit codes driven onto ALU OP)
//   seq_state_t : sequencer FSM states
//   helpers     : op legality, shift/direction classification, ALU op mapping
package mb_alu_seq_pkg;

  typedef enum logic [3:0] {
    ADD = 4'h0,
    SUB = 4'h1,
    AND = 4'h2,
    OR  = 4'h3,
    XOR = 4'h4,
    NOT = 4'h5,
    SL  = 4'h6,
    SR  = 4'h7
  } op_mne;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXE  = 3'd3,
    WR   = 3'd4,
    FIN  = 3'd5
  } seq_state_t;

  // Only the arithmetic/shift ops make sense chained across bytes.
  function automatic logic op_is_legal(input logic [3:0] o);
    return (o == ADD) || (o == SUB) || (o == SL) || (o == SR);
  endfunction

  // Shifts take a single operand, so the B read is skipped.
  function automatic logic op_is_shift(input logic [3:0] o);
    return (o == SL) || (o == SR);
  endfunction

  // SUB is performed on the ALU as A + ~B + carry.
  function automatic logic [3:0] alu_op_for(input logic [3:0] o);
    return (o == SUB) ? 4'(ADD) : o;
  endfunction

endpackage

// File: rtl/mb_addr_gen.sv
// Byte index counter and operand/destination address generator.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   load                : latch len/direction/bases and clear the index
//   step                : advance to the next byte
//   len                 : operand length in bytes (sampled on load)
//   msb_first           : walk bytes from base+len-1 down to base (SR)
//   base_a/base_b/base_d: LSB addresses (sampled on load)
//   last                : current byte is the final one
//   addr_a/addr_b/addr_d: addresses of the current byte, modulo 2^AW
module mb_addr_gen #(
  parameter int AW = 8,
  parameter int LW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load,
  input  logic          step,
  input  logic [LW-1:0] len,
  input  logic          msb_first,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_d,
  output logic          last,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [AW-1:0] addr_d
);

  logic [LW-1:0] idx_reg;
  logic [LW-1:0] len_reg;
  logic          msb_first_reg;
  logic [LW-1:0] offset_l;
  logic [AW-1:0] offset;
  logic [AW-1:0] base_in  [3];
  logic [AW-1:0] addr_arr [3];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx_reg       <= '0;
      len_reg       <= '0;
      msb_first_reg <= 1'b0;
    end else if (load) begin
      idx_reg       <= '0;
      len_reg       <= len;
      msb_first_reg <= msb_first;
    end else if (step) begin
      idx_reg <= idx_reg + LW'(1);
    end
  end

  // Offset from base: idx for LSB-first ops, len-1-idx for MSB-first.
  assign offset_l = msb_first_reg ? (len_reg - LW'(1) - idx_reg) : idx_reg;
  assign offset   = AW'(offset_l);
  assign last     = (idx_reg == (len_reg - LW'(1)));

  assign base_in[0] = base_a;
  assign base_in[1] = base_b;
  assign base_in[2] = base_d;

  // One latched base per stream; the adder wraps naturally at 2^AW.
  for (genvar gi = 0; gi < 3; gi++) begin : g_base
    logic [AW-1:0] base_reg;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        base_reg <= '0;
      end else if (load) begin
        base_reg <= base_in[gi];
      end
    end

    assign addr_arr[gi] = base_reg + offset;
  end

  assign addr_a = addr_arr[0];
  assign addr_b = addr_arr[1];
  assign addr_d = addr_arr[2];

endmodule

// File: rtl/mb_alu_seq.sv
// Multi-byte arithmetic sequencer for the 8-bit accumulator ALU.
// Reads N-byte operands one byte at a time from synchronous data memory,
// runs each byte through the ALU with the carry/shift bit chained from
// byte to byte, and writes each result byte back to memory.
// Ports:
//   Clk, Reset                : clock, synchronous active-high reset
//   start, op, len, cin       : request from the control unit
//   base_a, base_b, base_d    : LSB addresses of A, B and destination
//   busy, done, err           : handshake / status back to the control unit
//   carry_out, zero           : final flags, held until the next start
//   mem_addr, mem_rd_data,
//   mem_wr_en, mem_wr_data    : data memory port (read data one cycle late)
//   alu_op, alu_acc, alu_in,
//   alu_sc_in, alu_reg_exe,
//   alu_out, alu_sc_out       : ALU port
// Memory and ALU outputs are driven to idle values unless busy.
module mb_alu_seq
  import mb_alu_seq_pkg::*;
#(
  parameter int AW = 8,
  parameter int LW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [LW-1:0] len,
  input  logic          cin,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_d,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          carry_out,
  output logic          zero,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [3:0]    alu_op,
  output logic [7:0]    alu_acc,
  output logic [7:0]    alu_in,
  output logic          alu_sc_in,
  output logic          alu_reg_exe,
  input  logic [7:0]    alu_out,
  input  logic          alu_sc_out
);

  seq_state_t    state_reg;
  seq_state_t    state_next;
  logic [3:0]    op_reg;
  logic          c_reg;
  logic [7:0]    acc_reg;
  logic [7:0]    r_reg;
  logic          err_reg;
  logic          carry_out_reg;
  logic          zero_reg;

  logic          op_legal;
  logic          len_zero;
  logic          start_ok;
  logic          load;
  logic          step;
  logic          last;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [AW-1:0] addr_d;

  assign op_legal = op_is_legal(op);
  assign len_zero = (len == '0);
  assign start_ok = op_legal && !len_zero;
  assign load     = (state_reg == IDLE) && start && start_ok;
  assign step     = (state_reg == WR) && !last;

  mb_addr_gen #(
    .AW(AW),
    .LW(LW)
  ) u_addr_gen (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (load),
    .step      (step),
    .len       (len),
    .msb_first (op == SR),
    .base_a    (base_a),
    .base_b    (base_b),
    .base_d    (base_d),
    .last      (last),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .addr_d    (addr_d)
  );

  // Next state and Moore outputs.
  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    alu_op      = ADD;
    alu_acc     = '0;
    alu_in      = '0;
    alu_sc_in   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = start_ok ? RDA : FIN;
        end
      end
      RDA: begin
        busy       = 1'b1;
        mem_addr   = addr_a;
        state_next = op_is_shift(op_reg) ? EXE : RDB;
      end
      RDB: begin
        busy       = 1'b1;
        mem_addr   = addr_b;
        state_next = EXE;
      end
      EXE: begin
        busy      = 1'b1;
        // mem_rd_data holds B for ADD/SUB and A for shifts this cycle.
        alu_op    = alu_op_for(op_reg);
        alu_acc   = acc_reg;
        alu_in    = (op_reg == SUB) ? ~mem_rd_data : mem_rd_data;
        alu_sc_in = c_reg;
        state_next = WR;
      end
      WR: begin
        busy        = 1'b1;
        mem_addr    = addr_d;
        // A reset arriving in this cycle must not commit the write.
        mem_wr_en   = ~Reset;
        mem_wr_data = r_reg;
        state_next  = last ? FIN : RDA;
      end
      FIN: begin
        done       = 1'b1;
        err        = err_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign alu_reg_exe = 1'b1;
  assign carry_out   = carry_out_reg;
  assign zero        = zero_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      op_reg        <= ADD;
      c_reg         <= 1'b0;
      acc_reg       <= '0;
      r_reg         <= '0;
      err_reg       <= 1'b0;
      carry_out_reg <= 1'b0;
      zero_reg      <= 1'b1;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg  <= op;
            err_reg <= ~op_legal;
            // An illegal op leaves the previous flags untouched.
            if (op_legal) begin
              zero_reg <= 1'b1;
              c_reg    <= (op == SUB) ? 1'b1 : cin;
              if (len_zero) begin
                carry_out_reg <= 1'b0;
              end
            end
          end
        end
        RDB: begin
          acc_reg <= mem_rd_data;
        end
        EXE: begin
          r_reg    <= alu_out;
          c_reg    <= alu_sc_out;
          zero_reg <= zero_reg & (alu_out == 8'h00);
        end
        WR: begin
          // Publish the final carry so it is valid alongside done.
          if (last) begin
            carry_out_reg <= c_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
